// File: rtl/core_pkg.sv
// Types and constants shared by the fetch stage and its queue.
package core_pkg;

  localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] Pc;
    logic [31:0] Instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO of fetched instructions with synchronous flush.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           entry_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge Clock) begin
    if (!Reset || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge Clock) begin
    if (do_push && !flush_i) mem_q[wr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, speculatively issues one lookup per cycle, rewinds
// on a cache miss and queues hits for decode.
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [31:0] InstructionAddress,
  input  logic [31:0] Instruction,
  input  logic        InstructionReady,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPc,
  output logic        DecodeValid,
  output logic [31:0] DecodeInstruction,
  output logic [31:0] DecodePc,
  input  logic        DecodeReady
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]  Pc_q, Pc_d;
  logic [31:0]  PendingPc_q, PendingPc_d;
  logic         PendingValid_q, PendingValid_d;
  logic         push, pop, flush, issue;
  logic [CW-1:0] count;
  logic [CW:0]  occupancy;
  fetch_entry_t push_entry, head;

  // Conservative: an in-flight lookup reserves a slot, a same-cycle pop is ignored.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, PendingValid_q};
  assign issue     = occupancy < (CW+1)'(QUEUE_DEPTH);

  always_comb begin
    Pc_d           = Pc_q;
    PendingPc_d    = PendingPc_q;
    PendingValid_d = 1'b0;
    push           = 1'b0;
    flush          = 1'b0;
    if (RedirectValid) begin
      Pc_d  = RedirectPc & ~32'h3;
      flush = 1'b1;
    end else if (PendingValid_q && !InstructionReady) begin
      // Miss: replay the pending address, squashing this cycle's lookup.
      Pc_d = PendingPc_q;
    end else begin
      push = PendingValid_q;
      if (issue) begin
        PendingValid_d = 1'b1;
        PendingPc_d    = Pc_q;
        Pc_d           = Pc_q + INSTRUCTION_BYTES;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Pc_q           <= RESET_VECTOR;
      PendingValid_q <= 1'b0;
      PendingPc_q    <= RESET_VECTOR;
    end else begin
      Pc_q           <= Pc_d;
      PendingValid_q <= PendingValid_d;
      PendingPc_q    <= PendingPc_d;
    end
  end

  assign push_entry = '{Pc: PendingPc_q, Instruction: Instruction};
  assign pop        = DecodeValid && DecodeReady;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .Clock   (Clock),
    .Reset   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .entry_i (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign InstructionAddress = Pc_q;
  assign DecodeValid        = (count != '0);
  assign DecodeInstruction  = head.Instruction;
  assign DecodePc           = head.Pc;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and `instructioncache`. It owns the PC, presents `InstructionAddress` to the cache every cycle, and speculatively advances the PC so that cache hits sustain one instruction per cycle. On a miss it rewinds and replays. Accepted instructions, tagged with their PC, go into a small queue that drains to decode through a valid/ready handshake. A redirect from execute flushes all fetch state.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- `QUEUE_DEPTH`, default 4: fetch queue entries. Must be a power of two, at least 2.
- `Clock` in 1: the single clock. All state is updated on its rising edge.
- `Reset` in 1: reset is synchronous and active-low. Asserted when 0.
- `InstructionAddress` out 32: address presented to the cache. Equals the PC register.
- `Instruction` in 32: word returned by the cache.
- `InstructionReady` in 1: cache hit result for the address sampled on the previous edge.
- `RedirectValid` in 1: redirect request from execute.
- `RedirectPc` in 32: redirect target. Bits [1:0] are ignored (treated as 0).
- `DecodeValid` out 1: the queue head is valid.
- `DecodeInstruction` out 32: instruction at the queue head.
- `DecodePc` out 32: PC of the queue head.
- `DecodeReady` in 1: decode accepts the head this cycle.

## Operation
- Registers:
  - `Pc`
  - `PendingValid`, `PendingPc`: one in-flight lookup.
  - Queue contents, read/write pointers and `Count`.
- Issue condition: `Count + PendingValid < QUEUE_DEPTH`. The check is conservative and ignores a same-cycle pop.
- Issue cycle: `PendingValid<=1`, `PendingPc<=Pc`, `Pc<=Pc+4`. Arithmetic is mod 2^32; wrap from FFFF_FFFC to 0000_0000 is legal.
- No-issue cycle: `Pc` holds and `PendingValid<=0`. Any response arriving next cycle is ignored.
- Response, when `PendingValid=1`:
  - `InstructionReady=1`: push {`PendingPc`, `Instruction`}. A slot is guaranteed by the issue rule.
  - `InstructionReady=0` (miss or refill in progress): rewind with `Pc<=PendingPc` and `PendingValid<=0`. This squashes the lookup presented this cycle.
  - During a refill, fetch therefore alternates between issuing and rewinding on the same address until the cache hits.
- Priority, per cycle: Reset > Redirect > rewind > issue.
- Redirect (`RedirectValid=1`):
  - `Pc<={RedirectPc[31:2],2'b00}`, `PendingValid<=0`, queue flushed (`Count<=0`, pointers <=0).
  - Any response this cycle is discarded. A `DecodeReady` pop this cycle has no further effect.
  - No issue occurs in the redirect cycle.
- Decode side:
  - `DecodeValid = (Count != 0)`. `DecodeInstruction` and `DecodePc` come from the head entry.
  - A pop happens when `DecodeValid && DecodeReady`.
  - Push and pop in the same cycle leaves `Count` unchanged. Order is strictly preserved, with no duplicates and no drops.
- Reset:
  - `Pc<=RESET_VECTOR`, `PendingValid<=0`, `Count<=0`, pointers <=0. Queue data is left unreset.
  - Reset mid-refill is legal; fetch restarts from `RESET_VECTOR`.

## Timing
- Reset values of outputs: `InstructionAddress=RESET_VECTOR`, `DecodeValid=0`. `DecodeInstruction` and `DecodePc` are undefined while `DecodeValid=0`.
- First cycle with Reset=1: issues `RESET_VECTOR`.
- On a hit, `DecodeValid` rises 2 cycles later (issue c0, push at end of c1, visible in c2).
- Hit streaming with `DecodeReady=1` delivers one instruction per cycle.
- Miss penalty: the cache refill time plus at most 1 replay cycle after the cache returns to lookup.
- Redirect: `InstructionAddress` shows the target in the next cycle. The first target instruction reaches decode 3 cycles after the redirect cycle on a hit.
- `DecodeValid`, `DecodePc` and `DecodeInstruction` are registered (queue outputs) and have no combinational path from `DecodeReady`.
- Allowed combinational paths: `InstructionReady` and `RedirectValid` to internal next-state logic only. No input reaches an output combinationally.

## Structure
- Shared package `core_pkg`:
  - `fetch_entry_t` {`Pc` [31:0], `Instruction` [31:0]}.
  - Constant `INSTRUCTION_BYTES=4`.
- Sub-module `fetch_queue`:
  - Parameterized FIFO of `fetch_entry_t`, depth `QUEUE_DEPTH`, with synchronous flush.
  - Ports: push, pop, flush, `Count` output, head output.
- The top level holds the PC/pending logic and the issue/rewind/redirect priority.

## Test plan
- Reset: `RESET_VECTOR`=0x1000, Reset=0 for 3 cycles, then released. Required: `InstructionAddress`=0x1000 and `DecodeValid`=0 throughout reset; `DecodePc`=0x1000 two cycles after release.
- Streaming hits: cache model always hits, `DecodeReady`=1. Required: `DecodePc` 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles; `DecodeInstruction` matches the memory model.
- Miss on 0x1008, `InstructionReady`=0 for 10 cycles. Required:
  - `InstructionAddress` returns to 0x1008.
  - Nothing is pushed for 0x100C early.
  - 0x1008 is delivered within 1 cycle of the first hit, followed by 0x100C.
- Backpressure: `DecodeReady`=0 from the start. Required: `Count` reaches 4 with entries 0x1000–0x100C; `InstructionAddress` holds 0x1010. After release, exactly 0x1000… are delivered in order with no gaps.
- Redirect: `RedirectPc`=0x2003 while 3 entries are queued and a hit response is arriving. Required:
  - `DecodeValid`=0 the next cycle.
  - `InstructionAddress`=0x2000.
  - The next `DecodePc`=0x2000.
- Wrap and reset mid-refill:
  - Fetch from 0xFFFF_FFF8 with hits. Required: `DecodePc` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - Assert reset during a miss. Required: restart from `RESET_VECTOR` with an empty queue.
